// File: rtl/seq_magnitude_comparator_pkg.sv
// ---------------------------------------------------------------------------
// seq_magnitude_comparator_pkg
//   Shared definitions for the sequential magnitude comparator:
//   FSM state encoding, result encoding and a constant clog2 helper used to
//   size the chunk index counter.
// ---------------------------------------------------------------------------
package seq_magnitude_comparator_pkg;

  // FSM state encoding
  localparam logic [0:0] ST_IDLE    = 1'b0;
  localparam logic [0:0] ST_COMPARE = 1'b1;

  // Result encoding, decoded one-hot into the output flags
  localparam logic [1:0] RES_LT = 2'd0;
  localparam logic [1:0] RES_EQ = 2'd1;
  localparam logic [1:0] RES_GT = 2'd2;

  // Ceiling log2 for elaboration-time sizing
  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int v = value - 1; v > 0; v = v >> 1) begin
      result++;
    end
    return result;
  endfunction

endpackage

// File: rtl/seq_magnitude_comparator_if.sv
// ---------------------------------------------------------------------------
// seq_magnitude_comparator_if
//   Request/result bundle of the sequential magnitude comparator.
//   Request side : start, is_signed, a, b, lt_in, eq_in, gt_in
//   Result side  : busy, done, lt_out, eq_out, gt_out
//   master modport drives requests; slave modport is the comparator.
// ---------------------------------------------------------------------------
interface seq_magnitude_comparator_if
  import seq_magnitude_comparator_pkg::*;
#(
  parameter int WIDTH = 32
);

  logic             start;
  logic             is_signed;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             lt_in;
  logic             eq_in;
  logic             gt_in;
  logic             busy;
  logic             done;
  logic             lt_out;
  logic             eq_out;
  logic             gt_out;

  modport master (
    output start, is_signed, a, b, lt_in, eq_in, gt_in,
    input  busy, done, lt_out, eq_out, gt_out
  );

  modport slave (
    input  start, is_signed, a, b, lt_in, eq_in, gt_in,
    output busy, done, lt_out, eq_out, gt_out
  );

endinterface

// File: rtl/seq_magnitude_comparator_chunk_compare.sv
// ---------------------------------------------------------------------------
// chunk_compare
//   Combinational unsigned compare of one CHUNK-bit slice. With invert_msb
//   set, both MSBs are flipped first, which turns the top slice of a
//   two's-complement operand into an order-preserving unsigned value.
//   Ports: a, b (slices), invert_msb -> lt, gt
// ---------------------------------------------------------------------------
module chunk_compare #(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             invert_msb,
  output logic             lt,
  output logic             gt
);

  logic [CHUNK-1:0] flip;
  logic [CHUNK-1:0] a_adj;
  logic [CHUNK-1:0] b_adj;

  always_comb begin
    flip            = '0;
    flip[CHUNK-1]   = invert_msb;
  end

  assign a_adj = a ^ flip;
  assign b_adj = b ^ flip;
  assign lt    = (a_adj < b_adj);
  assign gt    = (a_adj > b_adj);

endmodule

// File: rtl/seq_magnitude_comparator.sv
// ---------------------------------------------------------------------------
// seq_magnitude_comparator
//   Multi-cycle magnitude comparator. Scans the captured operands MSB-first,
//   CHUNK bits per cycle, stopping at the first unequal chunk. Fully equal
//   operands resolve through the captured cascade inputs (gt_in over lt_in,
//   else EQ), keeping the classic LT/EQ/GT chaining contract.
//   Ports: clk, rst_n (synchronous, active-low), bus (slave modport).
// ---------------------------------------------------------------------------
module seq_magnitude_comparator
  import seq_magnitude_comparator_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CHUNK = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  seq_magnitude_comparator_if.slave    bus
);

  localparam int N   = WIDTH / CHUNK;
  localparam int K_W = (N > 1) ? clog2(N) : 1;
  localparam logic [K_W-1:0] K_TOP = K_W'(N - 1);

  logic [0:0]       state;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             signed_q;
  logic             lt_in_q;
  logic             gt_in_q;
  logic [K_W-1:0]   k;
  logic             done_q;
  logic             lt_q;
  logic             eq_q;
  logic             gt_q;

  logic [CHUNK-1:0] chunk_a;
  logic [CHUNK-1:0] chunk_b;
  logic             invert_msb;
  logic             chunk_lt;
  logic             chunk_gt;
  logic             resolved;
  logic [1:0]       res_next;
  logic             eq_in_unused;

  // The equal-operand outcome ignores eq_in; it exists only for chain compatibility.
  assign eq_in_unused = bus.eq_in;

  assign chunk_a    = a_q[int'(k) * CHUNK +: CHUNK];
  assign chunk_b    = b_q[int'(k) * CHUNK +: CHUNK];
  // Only the top chunk holds the sign bit.
  assign invert_msb = signed_q && (k == K_TOP);

  chunk_compare #(
    .CHUNK (CHUNK)
  ) u_chunk_compare (
    .a          (chunk_a),
    .b          (chunk_b),
    .invert_msb (invert_msb),
    .lt         (chunk_lt),
    .gt         (chunk_gt)
  );

  // A chunk difference decides immediately; an all-equal scan falls back on the cascade inputs.
  assign resolved = chunk_lt || chunk_gt || (k == '0);

  always_comb begin
    res_next = RES_EQ;
    if (chunk_gt) begin
      res_next = RES_GT;
    end else if (chunk_lt) begin
      res_next = RES_LT;
    end else if (gt_in_q) begin
      res_next = RES_GT;
    end else if (lt_in_q) begin
      res_next = RES_LT;
    end
  end

  // FSM, capture registers, chunk counter and result flags.
  // done_q defaults low each edge so it is a single-cycle pulse.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      signed_q <= 1'b0;
      lt_in_q  <= 1'b0;
      gt_in_q  <= 1'b0;
      k        <= '0;
      done_q   <= 1'b0;
      lt_q     <= 1'b0;
      eq_q     <= 1'b0;
      gt_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (bus.start) begin
            a_q      <= bus.a;
            b_q      <= bus.b;
            signed_q <= bus.is_signed;
            lt_in_q  <= bus.lt_in;
            gt_in_q  <= bus.gt_in;
            k        <= K_TOP;
            state    <= ST_COMPARE;
          end
        end
        ST_COMPARE: begin
          if (resolved) begin
            lt_q   <= (res_next == RES_LT);
            eq_q   <= (res_next == RES_EQ);
            gt_q   <= (res_next == RES_GT);
            done_q <= 1'b1;
            state  <= ST_IDLE;
          end else begin
            k <= k - 1'b1;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.busy   = (state == ST_COMPARE);
  assign bus.done   = done_q;
  assign bus.lt_out = lt_q;
  assign bus.eq_out = eq_q;
  assign bus.gt_out = gt_q;

endmodule
